mem_responder: RTL and testbench

- Memory-side endpoint of the channel interface driven by the memory controller.
- Accepts per-channel read/write requests, waits a fixed access latency, then returns a one-cycle ready pulse, plus read data for reads.
- Backed by an internal register-array memory with a host load port for preloading program or data images.
- Instantiated once for data memory and once for program memory (WRITE_ENABLE=0), replacing the testbench memory models.

---
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side channel endpoint: fixed-latency read/write responder over a register-array memory with a host preload port.
// Optional activity counters are compiled in with `define MEM_RESPONDER_STATS_EN.
module mem_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 16,
   parameter int NUM_CHANNELS = 1,
   parameter int LATENCY      = 2,
   parameter int WRITE_ENABLE = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
   input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]           mem_read_ready,
   output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
   input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]           mem_write_ready,
   input  logic                              load_valid,
   input  logic [ADDR_BITS-1:0]              load_address,
   input  logic [DATA_BITS-1:0]              load_data
`ifdef MEM_RESPONDER_STATS_EN
   ,
   output logic [31:0]                       stat_reads,
   output logic [31:0]                       stat_writes
`endif
);

   localparam int         DEPTH  = 1 << ADDR_BITS;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [2:0] {IDLE, READ_BUSY, WRITE_BUSY, RESPOND, DRAIN} state_t;

   logic [DATA_BITS-1:0]                      mem_q [DEPTH];
   logic [NUM_CHANNELS-1:0]                   rd_fire, wr_fire;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    ch_addr;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    ch_wdata;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      state_t               state_q, state_d;
      logic [3:0]           cnt_q, cnt_d;
      logic [ADDR_BITS-1:0] addr_q, addr_d;
      logic [DATA_BITS-1:0] wdata_q, wdata_d;
      logic                 is_rd_q, is_rd_d;
      logic                 rd_fire_c, wr_fire_c;
      logic [DATA_BITS-1:0] rdata_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_rd_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_rd_q <= is_rd_d;
         end
      end

      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         addr_d    = addr_q;
         wdata_d   = wdata_q;
         is_rd_d   = is_rd_q;
         rd_fire_c = 1'b0;
         wr_fire_c = 1'b0;
         case (state_q)
            IDLE: begin
               // Read has priority; a concurrent write stays pending until this read drains.
               if (mem_read_valid[c]) begin
                  addr_d  = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
                  cnt_d   = LAT_M1;
                  is_rd_d = 1'b1;
                  state_d = READ_BUSY;
               end else if (mem_write_valid[c]) begin
                  addr_d  = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
                  wdata_d = mem_write_data[c*DATA_BITS +: DATA_BITS];
                  cnt_d   = LAT_M1;
                  is_rd_d = 1'b0;
                  state_d = WRITE_BUSY;
               end
            end
            READ_BUSY, WRITE_BUSY: begin
               if (cnt_q == 4'd0) begin
                  rd_fire_c = (state_q == READ_BUSY);
                  wr_fire_c = (state_q == WRITE_BUSY);
                  state_d   = RESPOND;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            RESPOND: state_d = DRAIN;
            DRAIN: begin
               // The controller drops valid one cycle after it sees ready.
               if (is_rd_q ? !mem_read_valid[c] : !mem_write_valid[c])
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset)         rdata_q <= '0;
         else if (rd_fire_c) rdata_q <= mem_q[addr_q];
      end

      assign rd_fire[c]         = rd_fire_c;
      assign wr_fire[c]         = wr_fire_c;
      assign ch_addr[c]         = addr_q;
      assign ch_wdata[c]        = wdata_q;
      assign mem_read_ready[c]  = (state_q == RESPOND) &&  is_rd_q;
      assign mem_write_ready[c] = (state_q == RESPOND) && !is_rd_q;
      assign mem_read_data[c*DATA_BITS +: DATA_BITS] = rdata_q;
   end

   // Storage survives reset. Later assignments win: higher channel over lower, load over all.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if ((WRITE_ENABLE != 0) && wr_fire[c])
            mem_q[ch_addr[c]] <= ch_wdata[c];
      end
      if (load_valid)
         mem_q[load_address] <= load_data;
   end

`ifdef MEM_RESPONDER_STATS_EN
   logic [31:0] reads_q, writes_q;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? '1 : s[31:0];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reads_q  <= '0;
         writes_q <= '0;
      end else begin
         reads_q  <= sat_add(reads_q,  32'($countones(rd_fire)));
         writes_q <= sat_add(writes_q, 32'($countones(wr_fire)));
      end
   end

   assign stat_reads  = reads_q;
   assign stat_writes = writes_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: a 2-channel writable responder and a 1-channel read-only one share channel-0 stimulus.
module tb_mem_responder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rv, wv, rrdy, wrdy;
   logic [15:0] ra, wa;
   logic [31:0] wd, rdata;
   logic        lv;
   logic [7:0]  la;
   logic [15:0] ld;
   logic        ro_rrdy, ro_wrdy;
   logic [15:0] ro_rdata;

   mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2), .LATENCY(2), .WRITE_ENABLE(1)) dut (
      .clk(clk), .reset(reset),
      .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rrdy), .mem_read_data(rdata),
      .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wrdy),
      .load_valid(lv), .load_address(la), .load_data(ld));

   mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .LATENCY(2), .WRITE_ENABLE(0)) dut_ro (
      .clk(clk), .reset(reset),
      .mem_read_valid(rv[0]), .mem_read_address(ra[7:0]), .mem_read_ready(ro_rrdy), .mem_read_data(ro_rdata),
      .mem_write_valid(wv[0]), .mem_write_address(wa[7:0]), .mem_write_data(wd[15:0]), .mem_write_ready(ro_wrdy),
      .load_valid(lv), .load_address(la), .load_data(ld));

   typedef struct {bit rd; logic [15:0] data; int due;} exp_t;
   exp_t sb0[$], sb1[$], sbr[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // which: 0/1 = dut channel, 2 = read-only instance channel 0
   task automatic see(input int which, input bit rd, input logic [15:0] d);
      exp_t e;
      bit   got;
      got = 1'b0;
      case (which)
         0: if (sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
         1: if (sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
         default: if (sbr.size() > 0) begin e = sbr.pop_front(); got = 1'b1; end
      endcase
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL resp[%0d]: got unexpected %s ready at cyc %0d, expected none", which, rd ? "read" : "write", cyc);
      end else if (e.rd != rd || (rd && d !== e.data) || (e.due >= 0 && e.due != cyc)) begin
         failures++;
         $display("FAIL resp[%0d]: got rd=%0b data=%h cyc=%0d expected rd=%0b data=%h cyc=%0d",
                  which, rd, d, cyc, e.rd, e.data, e.due);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            if (rrdy[c]) see(c, 1'b1, rdata[c*16 +: 16]);
            if (wrdy[c]) see(c, 1'b0, 16'h0);
         end
         if (ro_rrdy) see(2, 1'b1, ro_rdata);
         if (ro_wrdy) see(2, 1'b0, 16'h0);
      end
   end

   task automatic push(input int ch, input bit rd, input logic [15:0] e, input logic [15:0] ero, input int due);
      exp_t x;
      x.rd = rd; x.data = e; x.due = due;
      if (ch == 0) begin
         sb0.push_back(x);
         x.data = ero;
         sbr.push_back(x);
      end else begin
         sb1.push_back(x);
      end
   endtask

   task automatic set_req(input int ch, input bit rd, input bit v, input logic [7:0] a, input logic [15:0] d);
      if (rd) begin
         rv[ch] = v; ra[ch*8 +: 8] = a;
      end else begin
         wv[ch] = v; wa[ch*8 +: 8] = a; wd[ch*16 +: 16] = d;
      end
   endtask

   task automatic wait_rdy(input int ch, input bit rd, input string nm);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (rd ? rrdy[ch] : wrdy[ch]) break;
         n++;
         if (n > 20) begin
            checks++; failures++;
            $display("FAIL timeout %s: got no ready in 20 cycles, expected one", nm);
            break;
         end
      end
   endtask

   task automatic op(input int ch, input bit rd, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] e, input logic [15:0] ero, input int hold, input string nm);
      @(negedge clk); set_req(ch, rd, 1'b1, a, d);
      @(posedge clk); #1; push(ch, rd, e, ero, cyc + 2);
      wait_rdy(ch, rd, nm);
      repeat (hold) @(negedge clk);
      set_req(ch, rd, 1'b0, a, d);
      repeat (2) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk); lv = 1'b1; la = a; ld = d;
      @(negedge clk); lv = 1'b0;
   endtask

   task automatic collide(input bit with_load);
      @(negedge clk);
      set_req(0, 1'b0, 1'b1, 8'h05, 16'h1111);
      set_req(1, 1'b0, 1'b1, 8'h05, 16'h2222);
      @(posedge clk); #1;
      push(0, 1'b0, 16'h0, 16'h0, cyc + 2);
      push(1, 1'b0, 16'h0, 16'h0, cyc + 2);
      @(negedge clk); @(negedge clk);
      if (with_load) begin lv = 1'b1; la = 8'h05; ld = 16'h3333; end
      @(negedge clk);
      lv = 1'b0;
      set_req(0, 1'b0, 1'b0, 8'h05, 16'h1111);
      set_req(1, 1'b0, 1'b0, 8'h05, 16'h2222);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rv = '0; wv = '0; ra = '0; wa = '0; wd = '0; lv = 1'b0; la = '0; ld = '0;
      repeat (2) @(negedge clk);
      chk("rst_rrdy", {30'h0, rrdy}, 32'h0);
      chk("rst_wrdy", {30'h0, wrdy}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ro", {14'h0, ro_rrdy, ro_wrdy, ro_rdata}, 32'h0);
      reset = 1'b1;

      load(8'h10, 16'hBEEF); load(8'h22, 16'h5555); load(8'h05, 16'h0F0F); load(8'h30, 16'h7777);

      op(0, 1'b1, 8'h10, 16'h0, 16'hBEEF, 16'hBEEF, 0, "rd_preload");
      repeat (3) @(negedge clk);
      chk("rdata_hold", {16'h0, rdata[15:0]}, 32'hBEEF);
      chk("ro_rdata_hold", {16'h0, ro_rdata}, 32'hBEEF);

      op(0, 1'b0, 8'h22, 16'h1234, 16'h0, 16'h0, 0, "wr_22");
      op(0, 1'b1, 8'h22, 16'h0, 16'h1234, 16'h5555, 0, "rd_22");

      op(0, 1'b1, 8'h10, 16'h0, 16'hBEEF, 16'hBEEF, 3, "held_valid");
      op(0, 1'b1, 8'h22, 16'h0, 16'h1234, 16'h5555, 0, "after_hold");
      op(1, 1'b1, 8'h10, 16'h0, 16'hBEEF, 16'h0, 0, "ch1_rd");

      collide(1'b0);
      op(0, 1'b1, 8'h05, 16'h0, 16'h2222, 16'h0F0F, 0, "collide");
      collide(1'b1);
      op(0, 1'b1, 8'h05, 16'h0, 16'h3333, 16'h3333, 0, "collide_load");

      // Read and write both valid: read first with old data, write accepted after the read drains.
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 8'h10, 16'h0);
      set_req(0, 1'b0, 1'b1, 8'h10, 16'hCAFE);
      @(posedge clk); #1;
      push(0, 1'b1, 16'hBEEF, 16'hBEEF, cyc + 2);
      push(0, 1'b0, 16'h0, 16'h0, cyc + 7);
      wait_rdy(0, 1'b1, "rdwr_rd");
      set_req(0, 1'b1, 1'b0, 8'h10, 16'h0);
      wait_rdy(0, 1'b0, "rdwr_wr");
      set_req(0, 1'b0, 1'b0, 8'h10, 16'hCAFE);
      repeat (2) @(negedge clk);
      op(0, 1'b1, 8'h10, 16'h0, 16'hCAFE, 16'hBEEF, 0, "rd_after_wr");

      // Reset while the write is in flight: no ack, no commit.
      @(negedge clk);
      set_req(0, 1'b0, 1'b1, 8'h30, 16'hAAAA);
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_rdy", {28'h0, rrdy, wrdy}, 32'h0);
      chk("midrst_rdata", rdata, 32'h0);
      chk("midrst_ro", {14'h0, ro_rrdy, ro_wrdy, ro_rdata}, 32'h0);
      set_req(0, 1'b0, 1'b0, 8'h30, 16'hAAAA);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      op(0, 1'b1, 8'h30, 16'h0, 16'h7777, 16'h7777, 0, "rd_30");

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb0.size() + sb1.size() + sbr.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
